bist_lfsr_misr: RTL
===================

# bist_lfsr_misr

Self-test wrapper stage that sits on both sides of the 3-input / 6-output s526 benchmark circuit. It drives the CUT primary inputs (G0, G1, G2) from an internal LFSR and compacts the CUT primary outputs (G147, G148, G198, G199, G213, G214) into a multiple-input signature register (MISR). A start/done handshake runs one complete session: init, run, drain, compare. The final signature is compared against a golden value to produce pass/fail for the fault-simulation flow.

## Interface
Parameters:
- PATTERNS, 1000: number of pseudo-random vectors applied; legal range 1..65535.
- INIT_CYCLES, 8: cycles of the initialisation vector before the run; legal range 1..255.
- LFSR_SEED, 16'hACE1: LFSR load value; must be nonzero.
- MISR_SEED, 16'h0000: MISR load value.
- GOLDEN, 16'h0000: expected final signature.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  session request; sampled only in IDLE or DONE.
- cut_pi  out  3  CUT inputs: {G2, G1, G0}.
- cut_po  in  6  CUT outputs: {G214, G213, G199, G198, G148, G147}.
- busy  out  1  high in INIT, RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid only while done is high; equals (signature == GOLDEN).
- signature  out  16  current MISR contents.

## Operation
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE, and start=1 sampled: load lfsr=LFSR_SEED, misr=MISR_SEED, cnt=0, cap_en=0; go to INIT.
- INIT:
  - cut_pi=3'b001 (G0=1 forces the CUT flops toward their clear state).
  - Stay INIT_CYCLES cycles, then go to RUN with cnt=0.
- RUN:
  - cut_pi=lfsr[2:0]; the LFSR advances every RUN cycle.
  - After PATTERNS cycles, go to DRAIN.
- DRAIN: one cycle, cut_pi=3'b000; then go to DONE.
- DONE:
  - done=1; pass and signature are held.
  - start=1 sampled here restarts exactly as from IDLE.
- LFSR:
  - Fibonacci, x^16+x^14+x^13+x^11+1.
  - fb = q[15]^q[13]^q[12]^q[10]; next = {q[14:0], fb}.
  - Never updates outside RUN.
- MISR:
  - Same polynomial. next = {m[14:0], fbm} ^ {10'b0, cut_po}, with fbm = m[15]^m[13]^m[12]^m[10].
  - Updates only when cap_en=1.
- cap_en: register loaded each cycle with (state==RUN). Capture is therefore delayed one cycle, matching the CUT's registered outputs.
  - Captures occur at the ends of RUN cycles 2..PATTERNS and at the end of DRAIN.
  - This gives exactly PATTERNS captures.
- Counter: 16 bits for RUN, 8 bits for INIT; no wrap within legal parameter ranges.
- start is ignored while busy=1.
- start held high in DONE retriggers on every DONE cycle; a level-held start therefore loops sessions back-to-back.

## Timing
- Reset: state=IDLE, cut_pi=3'b000, busy=0, done=0, pass=0, signature=MISR_SEED, lfsr=LFSR_SEED, cap_en=0.
- RST high in any state, including mid-RUN, aborts to the reset state at the next edge. No partial done or pass is produced.
- Latency: start sampled at edge e0 gives done=1 after edge e0+INIT_CYCLES+PATTERNS+2.
- Same-edge behaviour:
  - busy falls on the same edge that done rises.
  - In DONE with start=1, done falls and busy rises on the same edge.
- pass and signature are stable throughout DONE.
- cut_pi changes only on clock edges; all outputs are registered.

## Test plan
- Reset values: reset then idle 5 cycles -> cut_pi=000, busy=0, done=0, signature=16'h0000, pass=0.
- LFSR sequence, default seed: first RUN cycle cut_pi=3'b001, second RUN cycle cut_pi=3'b011 (lfsr 16'hACE1 -> 16'h59C3).
- Single pattern: PATTERNS=1, INIT_CYCLES=1, cut_po tied 6'b000001.
  - done rises 4 edges after start.
  - signature=16'h0001; pass=1 when GOLDEN=16'h0001, pass=0 when GOLDEN=16'h0000.
- Two patterns: PATTERNS=2, cut_po tied 6'h3F -> signature=16'h0041.
- Abort and restart: assert RST mid-RUN -> IDLE next edge, busy=0, done=0. A new start then completes with the same signature as an uninterrupted run.
- Full session against the s526 netlist, defaults: done exactly 1010 edges after start; signature matches the bench golden model. A single stuck-at fault injected on G13 gives a different signature and pass=0.

Source files
------------

// File: rtl/bist_lfsr_misr.sv
// bist_lfsr_misr: LFSR stimulus and MISR compaction around the s526 CUT, run as one start/done self-test session
module bist_lfsr_misr #(
  parameter int          PATTERNS    = 1000,
  parameter int          INIT_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] MISR_SEED   = 16'h0000,
  parameter logic [15:0] GOLDEN      = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
  output logic [2:0]  cut_pi,
  input  logic [5:0]  cut_po,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] TAPS = 16'hB400;
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, misr_q, misr_d, cnt_q, cnt_d;
  logic        cap_en_q, last, counting;
  always_comb begin
    counting = state_q == INIT || state_q == RUN;
    last = cnt_q == (state_q == INIT ? 16'(INIT_CYCLES - 1) : 16'(PATTERNS - 1));
    state_d = state_q;
    cnt_d = counting ? (last ? 16'd0 : cnt_q + 16'd1) : cnt_q;
    lfsr_d = state_q == RUN ? {lfsr_q[14:0], ^(lfsr_q & TAPS)} : lfsr_q;
    misr_d = cap_en_q ? {misr_q[14:0], ^(misr_q & TAPS)} ^ {10'b0, cut_po} : misr_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        cnt_d = 16'd0;
        lfsr_d = LFSR_SEED;
        misr_d = MISR_SEED;
      end
      INIT:    state_d = last ? RUN : INIT;
      RUN:     state_d = last ? DRAIN : RUN;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the current state, so they trail it by one cycle
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      misr_q <= MISR_SEED;
      cnt_q <= 16'd0;
      cap_en_q <= 1'b0;
      cut_pi <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      signature <= MISR_SEED;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      cnt_q <= cnt_d;
      cap_en_q <= state_q == RUN;
      cut_pi <= state_q == INIT ? 3'b001 : state_q == RUN ? lfsr_q[2:0] : 3'b000;
      busy <= state_q == INIT || state_q == RUN || state_q == DRAIN;
      done <= state_q == DONE;
      pass <= state_q == DONE && misr_q == GOLDEN;
      signature <= misr_q;
    end
  end
endmodule
